// File: rtl/calc_display_pkg.sv
// Shared constants for the result display path: active-low 7-segment patterns
// (bit order gfedcba) and the converter FSM state type.
package calc_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      UPDATE
   } state_t;

endpackage

// File: rtl/decodificador_7seg.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 decode to blank.
module decodificador_7seg
   import calc_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (bcd)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/conversor_resultado_display.sv
// Converts a binary result to decimal 7-segment digits with a sequential
// double-dabble engine (one shift per clock), sign digit and zero blanking.
module conversor_resultado_display
   import calc_display_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] valor,
   input  logic             modo_sinal,
   output logic             busy,
   output logic             done,
   output logic [6:0]       hex0,
   output logic [6:0]       hex1,
   output logic [6:0]       hex2,
   output logic [6:0]       hex3
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned SH_W  = BCD_W + WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state;
   logic [SH_W-1:0]    shreg;
   logic [CNT_W-1:0]   count;
   logic               neg;
   logic [BCD_W-1:0]   bcd_adj;
   logic [3:0]         dig_u, dig_t, dig_h;
   logic [6:0]         seg_u, seg_t, seg_h;

   assign dig_u = shreg[WIDTH     +: 4];
   assign dig_t = shreg[WIDTH + 4 +: 4];
   assign dig_h = shreg[WIDTH + 8 +: 4];

   // Add-3 correction on every BCD nibble that would overflow past 9 when doubled
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (shreg[WIDTH + 4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = shreg[WIDTH + 4*i +: 4] + 4'd3;
         else
            bcd_adj[4*i +: 4] = shreg[WIDTH + 4*i +: 4];
      end
   end

   decodificador_7seg u_dec_u (.bcd(dig_u), .seg_c(seg_u));
   decodificador_7seg u_dec_t (.bcd(dig_t), .seg_c(seg_t));
   decodificador_7seg u_dec_h (.bcd(dig_h), .seg_c(seg_h));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hex0  <= SEG_0;
         hex1  <= SEG_BLANK;
         hex2  <= SEG_BLANK;
         hex3  <= SEG_BLANK;
         shreg <= '0;
         count <= '0;
         neg   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  neg   <= modo_sinal & valor[WIDTH-1];
                  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
                  shreg <= {BCD_W'(0), (modo_sinal & valor[WIDTH-1]) ? (~valor + WIDTH'(1)) : valor};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= CONVERT;
               end
            end
            CONVERT: begin
               shreg <= {bcd_adj, shreg[WIDTH-1:0]} << 1;
               count <= count + CNT_W'(1);
               if (count == CNT_W'(WIDTH - 1))
                  state <= UPDATE;
            end
            UPDATE: begin
               hex0  <= seg_u;
               hex1  <= (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg_t;
               hex2  <= (dig_h == 4'd0) ? SEG_BLANK : seg_h;
               hex3  <= neg ? SEG_MINUS : SEG_BLANK;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conversor_resultado_display.sv
// Self-checking bench for conversor_resultado_display: arithmetic reference
// model compared every cycle, plus literal expectations per directed vector.
module tb_conversor_resultado_display;

   localparam int unsigned WIDTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       modo_sinal = 1'b0;
   logic [7:0] valor = 8'd0;
   logic       busy, done;
   logic [6:0] hex0, hex1, hex2, hex3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conversor_resultado_display #(.WIDTH(8), .DIGITS(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .valor      (valor),
      .modo_sinal (modo_sinal),
      .busy       (busy),
      .done       (done),
      .hex0       (hex0),
      .hex1       (hex1),
      .hex2       (hex2),
      .hex3       (hex3)
   );

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: value -> decimal digits by division, timing as a countdown
   logic       m_busy = 1'b0, m_done = 1'b0;
   logic [6:0] m_hex0 = 7'h40, m_hex1 = 7'h7F, m_hex2 = 7'h7F, m_hex3 = 7'h7F;
   logic [6:0] p_hex0, p_hex1, p_hex2, p_hex3;
   int         m_left = 0;
   int         mag, dh, dt, du;
   bit         mneg;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0;
         m_hex0 = 7'h40; m_hex1 = 7'h7F; m_hex2 = 7'h7F; m_hex3 = 7'h7F;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1;
               m_hex0 = p_hex0; m_hex1 = p_hex1; m_hex2 = p_hex2; m_hex3 = p_hex3;
            end
         end else if (start) begin
            mneg = modo_sinal && valor[7];
            mag  = mneg ? 256 - int'(valor) : int'(valor);
            dh = mag / 100; dt = (mag / 10) % 10; du = mag % 10;
            p_hex0 = seg(du);
            p_hex1 = (dh == 0 && dt == 0) ? 7'h7F : seg(dt);
            p_hex2 = (dh == 0) ? 7'h7F : seg(dh);
            p_hex3 = mneg ? 7'h3F : 7'h7F;
            m_left = WIDTH + 1;
            m_busy = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", {6'd0, busy}, {6'd0, m_busy});
      chk("done", {6'd0, done}, {6'd0, m_done});
      chk("hex0", hex0, m_hex0);
      chk("hex1", hex1, m_hex1);
      chk("hex2", hex2, m_hex2);
      chk("hex3", hex3, m_hex3);
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // One-cycle start, optional ignored start mid-conversion, then latency and digit checks
   task automatic conv(input logic [7:0] v, input logic m, input string name,
                       input logic [6:0] e3, input logic [6:0] e2,
                       input logic [6:0] e1, input logic [6:0] e0, input bit intrude);
      int lat;
      lat = 0;
      valor = v; modo_sinal = m; start = 1'b1;
      while (lat < 30) begin
         step();
         lat++;
         if (lat == 1) start = 1'b0;
         if (intrude && lat == 4) begin start = 1'b1; valor = 8'd99; modo_sinal = 1'b1; end
         if (intrude && lat == 5) start = 1'b0;
         if (done) break;
      end
      checks++;
      if (lat != 10) begin
         errors++;
         $display("FAIL %s_latency: got %0d expected 10", name, lat);
      end
      chk({name, "_hex3"}, hex3, e3);
      chk({name, "_hex2"}, hex2, e2);
      chk({name, "_hex1"}, hex1, e1);
      chk({name, "_hex0"}, hex0, e0);
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_hex0", hex0, 7'h40);
      chk("rst_hex1", hex1, 7'h7F);
      chk("rst_hex2", hex2, 7'h7F);
      chk("rst_hex3", hex3, 7'h7F);
      chk("rst_busy", {6'd0, busy}, 7'd0);

      step();
      conv(8'd255, 1'b0, "u255",  7'h7F, 7'h24, 7'h12, 7'h12, 1'b0);
      step();
      conv(8'hF6,  1'b1, "m10",   7'h3F, 7'h7F, 7'h79, 7'h40, 1'b0);
      step();
      conv(8'h80,  1'b1, "m128",  7'h3F, 7'h79, 7'h24, 7'h00, 1'b0);
      step();
      conv(8'h80,  1'b0, "u128",  7'h7F, 7'h79, 7'h24, 7'h00, 1'b0);
      step();
      conv(8'd0,   1'b1, "zero",  7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b0);
      step();
      conv(8'd7,   1'b0, "seven", 7'h7F, 7'h7F, 7'h7F, 7'h78, 1'b1);
      conv(8'd42,  1'b0, "back2back", 7'h7F, 7'h7F, 7'h19, 7'h24, 1'b0);

      step();
      valor = 8'd200; modo_sinal = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      chk("abort_hex0", hex0, 7'h40);
      chk("abort_hex1", hex1, 7'h7F);
      chk("abort_hex2", hex2, 7'h7F);
      chk("abort_busy", {6'd0, busy}, 7'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("abort_nodone", {6'd0, done}, 7'd0);
      end
      conv(8'd200, 1'b0, "u200", 7'h7F, 7'h24, 7'h40, 7'h40, 1'b0);

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
